// File: rtl/kvs_pkg.sv
// rtl/kvs_pkg.sv - shared widths and database flag encodings for the KV lookup arbiter
package kvs_pkg;

    localparam int KEY_SIZE_DEF = 96;
    localparam int FLAG_W_DEF   = 4;
    localparam int REQ_ID_W     = 1;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef enum logic [3:0] {
        DB_OP_SUSPECT_INSERT = 4'b0011,
        DB_OP_ARREST_LOOKUP  = 4'b0101
    } db_op_e;

endpackage

// File: rtl/kvs_sync_fifo.sv
// rtl/kvs_sync_fifo.sv - synchronous FIFO with combinational head, async active-high reset
module kvs_sync_fifo
    import kvs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count = r_wptr - r_rptr;
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    // Empty+push+pop is a pass-through; full+push+pop reuses the slot being vacated.
    assign w_do_pop  = i_pop && (!o_empty || i_push);
    assign w_do_push = i_push && (!o_full || i_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/kvs_req_arbiter.sv
// rtl/kvs_req_arbiter.sv - round-robin sharing of one KV database lookup port between two parsers
module kvs_req_arbiter
    import kvs_pkg::*;
#(
    parameter int KEY_SIZE   = KEY_SIZE_DEF,
    parameter int FLAG_W     = FLAG_W_DEF,
    parameter int QDEPTH     = 4,
    parameter int OUTS_DEPTH = 8
) (
    input  logic                clk156,
    input  logic                eth_rst,
    input  logic [KEY_SIZE-1:0] r0_key,
    input  logic [FLAG_W-1:0]   r0_flag,
    input  logic                r0_valid,
    output logic                r0_resp_valid,
    output logic [FLAG_W-1:0]   r0_resp_flag,
    input  logic [KEY_SIZE-1:0] r1_key,
    input  logic [FLAG_W-1:0]   r1_flag,
    input  logic                r1_valid,
    output logic                r1_resp_valid,
    output logic [FLAG_W-1:0]   r1_resp_flag,
    output logic [KEY_SIZE-1:0] db_key,
    output logic [FLAG_W-1:0]   db_flag,
    output logic                db_valid,
    input  logic                db_ready,
    input  logic                db_resp_valid,
    input  logic [FLAG_W-1:0]   db_resp_flag,
    output logic [7:0]          drop_cnt0,
    output logic [7:0]          drop_cnt1,
    output logic                err_orphan
);

    localparam int QW  = KEY_SIZE + FLAG_W;
    localparam int QCW = $clog2(QDEPTH) + 1;
    localparam int OCW = $clog2(OUTS_DEPTH) + 1;

    logic [QW-1:0]       w_q0_head, w_q1_head, w_issue_head;
    logic                w_q0_full, w_q0_empty, w_q0_pop;
    logic                w_q1_full, w_q1_empty, w_q1_pop;
    logic [QCW-1:0]      w_unused_q0_count, w_unused_q1_count;
    logic [OCW-1:0]      w_unused_ord_count;
    logic                w_ord_full, w_ord_empty;
    req_id_t             w_ord_head, w_win, w_resp_id;
    logic                w_slot_free, w_issue, w_orphan, w_drop0, w_drop1;

    logic [KEY_SIZE-1:0] r_db_key;
    logic [FLAG_W-1:0]   r_db_flag;
    logic                r_db_valid;
    req_id_t             r_rr_last;
    logic                r_r0_resp_valid, r_r1_resp_valid, r_err_orphan;
    logic [FLAG_W-1:0]   r_r0_resp_flag, r_r1_resp_flag;
    logic [7:0]          r_drop_cnt0, r_drop_cnt1;

    kvs_sync_fifo #(.WIDTH(QW), .DEPTH(QDEPTH)) u_q0 (
        .i_clk(clk156), .i_rst(eth_rst),
        .i_push(r0_valid), .i_push_data({r0_key, r0_flag}), .i_pop(w_q0_pop),
        .o_head(w_q0_head), .o_full(w_q0_full), .o_empty(w_q0_empty), .o_count(w_unused_q0_count)
    );

    kvs_sync_fifo #(.WIDTH(QW), .DEPTH(QDEPTH)) u_q1 (
        .i_clk(clk156), .i_rst(eth_rst),
        .i_push(r1_valid), .i_push_data({r1_key, r1_flag}), .i_pop(w_q1_pop),
        .o_head(w_q1_head), .o_full(w_q1_full), .o_empty(w_q1_empty), .o_count(w_unused_q1_count)
    );

    kvs_sync_fifo #(.WIDTH(REQ_ID_W), .DEPTH(OUTS_DEPTH)) u_ord (
        .i_clk(clk156), .i_rst(eth_rst),
        .i_push(w_issue), .i_push_data(w_win), .i_pop(db_resp_valid),
        .o_head(w_ord_head), .o_full(w_ord_full), .o_empty(w_ord_empty), .o_count(w_unused_ord_count)
    );

    always_comb begin
        w_win = '0;
        if (!w_q0_empty && !w_q1_empty) w_win = ~r_rr_last;
        else if (w_q0_empty)            w_win = 1'b1;
    end

    assign w_slot_free  = !r_db_valid || db_ready;
    assign w_issue      = w_slot_free && (!w_ord_full || db_resp_valid) && !(w_q0_empty && w_q1_empty);
    assign w_q0_pop     = w_issue && (w_win == 1'b0);
    assign w_q1_pop     = w_issue && (w_win == 1'b1);
    assign w_issue_head = (w_win == 1'b1) ? w_q1_head : w_q0_head;

    // A response landing on an empty ordering FIFO belongs to the request issued on the same edge.
    assign w_resp_id = w_ord_empty ? w_win : w_ord_head;
    assign w_orphan  = db_resp_valid && w_ord_empty && !w_issue;
    assign w_drop0   = r0_valid && w_q0_full && !w_q0_pop;
    assign w_drop1   = r1_valid && w_q1_full && !w_q1_pop;

    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            r_db_valid <= 1'b0;
            r_db_key   <= '0;
            r_db_flag  <= '0;
            r_rr_last  <= 1'b1;
        end else if (w_issue) begin
            {r_db_key, r_db_flag} <= w_issue_head;
            r_db_valid            <= 1'b1;
            r_rr_last             <= w_win;
        end else if (w_slot_free) begin
            r_db_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            r_r0_resp_valid <= 1'b0;
            r_r1_resp_valid <= 1'b0;
            r_r0_resp_flag  <= '0;
            r_r1_resp_flag  <= '0;
            r_err_orphan    <= 1'b0;
        end else begin
            r_r0_resp_valid <= 1'b0;
            r_r1_resp_valid <= 1'b0;
            if (db_resp_valid && !w_orphan) begin
                if (w_resp_id == 1'b0) begin
                    r_r0_resp_valid <= 1'b1;
                    r_r0_resp_flag  <= db_resp_flag;
                end else begin
                    r_r1_resp_valid <= 1'b1;
                    r_r1_resp_flag  <= db_resp_flag;
                end
            end
            if (w_orphan) r_err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            r_drop_cnt0 <= '0;
            r_drop_cnt1 <= '0;
        end else begin
            if (w_drop0 && (r_drop_cnt0 != 8'hFF)) r_drop_cnt0 <= r_drop_cnt0 + 8'd1;
            if (w_drop1 && (r_drop_cnt1 != 8'hFF)) r_drop_cnt1 <= r_drop_cnt1 + 8'd1;
        end
    end

    assign db_key        = r_db_key;
    assign db_flag       = r_db_flag;
    assign db_valid      = r_db_valid;
    assign r0_resp_valid = r_r0_resp_valid;
    assign r0_resp_flag  = r_r0_resp_flag;
    assign r1_resp_valid = r_r1_resp_valid;
    assign r1_resp_flag  = r_r1_resp_flag;
    assign drop_cnt0     = r_drop_cnt0;
    assign drop_cnt1     = r_drop_cnt1;
    assign err_orphan    = r_err_orphan;

endmodule

// File: tb/tb_kvs_req_arbiter.sv
// tb/tb_kvs_req_arbiter.sv - queue-based reference model and response scoreboard for kvs_req_arbiter
module tb_kvs_req_arbiter;

    localparam int KEY_SIZE   = 96;
    localparam int FLAG_W     = 4;
    localparam int QDEPTH     = 4;
    localparam int OUTS_DEPTH = 8;

    typedef struct packed { logic [95:0] key; logic [3:0] flag; } req_t;
    typedef struct { int id; logic [3:0] flag; } resp_t;

    logic        clk156 = 1'b0;
    logic        eth_rst = 1'b1;
    logic [95:0] r0_key = '0, r1_key = '0;
    logic [3:0]  r0_flag = '0, r1_flag = '0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        db_ready = 1'b0, db_resp_valid = 1'b0;
    logic [3:0]  db_resp_flag = '0;
    logic        r0_resp_valid, r1_resp_valid, db_valid, err_orphan;
    logic [3:0]  r0_resp_flag, r1_resp_flag, db_flag;
    logic [95:0] db_key;
    logic [7:0]  drop_cnt0, drop_cnt1;

    kvs_req_arbiter #(.KEY_SIZE(KEY_SIZE), .FLAG_W(FLAG_W), .QDEPTH(QDEPTH), .OUTS_DEPTH(OUTS_DEPTH)) dut (
        .clk156(clk156), .eth_rst(eth_rst),
        .r0_key(r0_key), .r0_flag(r0_flag), .r0_valid(r0_valid),
        .r0_resp_valid(r0_resp_valid), .r0_resp_flag(r0_resp_flag),
        .r1_key(r1_key), .r1_flag(r1_flag), .r1_valid(r1_valid),
        .r1_resp_valid(r1_resp_valid), .r1_resp_flag(r1_resp_flag),
        .db_key(db_key), .db_flag(db_flag), .db_valid(db_valid), .db_ready(db_ready),
        .db_resp_valid(db_resp_valid), .db_resp_flag(db_resp_flag),
        .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1), .err_orphan(err_orphan)
    );

    always #5 clk156 = ~clk156;

    int checks = 0;
    int errors = 0;

    // Reference state: pending requests per port, the one issued lookup, and ids awaiting responses.
    req_t       mq0[$];
    req_t       mq1[$];
    bit         m_sv;
    req_t       m_slot;
    int         m_rr;
    int         m_outs[$];
    int         m_drop[2];
    bit         m_err;
    bit         m_rv[2];
    logic [3:0] m_rf[2];
    resp_t      exp_resp[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq0.delete(); mq1.delete(); m_outs.delete(); exp_resp.delete();
        m_sv = 0; m_slot = '0; m_rr = 1; m_err = 0;
        m_drop[0] = 0; m_drop[1] = 0; m_rv[0] = 0; m_rv[1] = 0;
        m_rf[0] = '0; m_rf[1] = '0;
    endtask

    task automatic model_step();
        bit    have0, have1, slot_free, iss, bypass;
        int    win, id;
        resp_t r;
        have0     = mq0.size() > 0;
        have1     = mq1.size() > 0;
        slot_free = !m_sv || db_ready;
        iss       = slot_free && (m_outs.size() < OUTS_DEPTH || db_resp_valid) && (have0 || have1);
        win       = (have0 && have1) ? 1 - m_rr : (have0 ? 0 : 1);
        bypass    = 0;
        m_rv[0] = 0; m_rv[1] = 0;
        if (db_resp_valid) begin
            id = -1;
            if (m_outs.size() > 0) id = m_outs.pop_front();
            else if (iss) begin id = win; bypass = 1; end
            else m_err = 1;
            if (id >= 0) begin
                m_rv[id] = 1; m_rf[id] = db_resp_flag;
                r.id = id; r.flag = db_resp_flag;
                exp_resp.push_back(r);
            end
        end
        if (iss) begin
            m_slot = (win == 0) ? mq0.pop_front() : mq1.pop_front();
            m_sv = 1; m_rr = win;
            if (!bypass) m_outs.push_back(win);
        end else if (slot_free) begin
            m_sv = 0;
        end
        if (r0_valid) begin
            if (mq0.size() < QDEPTH) mq0.push_back(req_t'({r0_key, r0_flag}));
            else if (m_drop[0] < 255) m_drop[0]++;
        end
        if (r1_valid) begin
            if (mq1.size() < QDEPTH) mq1.push_back(req_t'({r1_key, r1_flag}));
            else if (m_drop[1] < 255) m_drop[1]++;
        end
    endtask

    initial forever begin
        @(posedge clk156);
        if (!eth_rst) model_step();
    end

    initial forever begin
        resp_t e;
        @(negedge clk156);
        chk("db_valid", db_valid, m_sv);
        if (m_sv) begin
            chk("db_key", db_key, m_slot.key);
            chk("db_flag", db_flag, m_slot.flag);
        end
        chk("drop_cnt0", drop_cnt0, m_drop[0]);
        chk("drop_cnt1", drop_cnt1, m_drop[1]);
        chk("err_orphan", err_orphan, m_err);
        chk("r0_resp_valid", r0_resp_valid, m_rv[0]);
        chk("r1_resp_valid", r1_resp_valid, m_rv[1]);
        chk("r0_resp_flag", r0_resp_flag, m_rf[0]);
        chk("r1_resp_flag", r1_resp_flag, m_rf[1]);
        if (r0_resp_valid || r1_resp_valid) begin
            chk("resp_pending", exp_resp.size(), 1);
            chk("resp_one_hot", r0_resp_valid & r1_resp_valid, 1'b0);
            if (exp_resp.size() > 0) begin
                e = exp_resp.pop_front();
                chk("resp_id", r1_resp_valid, e.id);
                chk("resp_flag_sb", r1_resp_valid ? r1_resp_flag : r0_resp_flag, e.flag);
            end
        end else begin
            chk("resp_missing", exp_resp.size(), 0);
        end
    end

    task automatic tick();
        @(negedge clk156);
        #1;
        r0_valid = 0; r1_valid = 0; db_resp_valid = 0;
    endtask

    task automatic do_reset();
        eth_rst = 1;
        model_clear();
        tick(); tick();
        eth_rst = 0;
    endtask

    function automatic logic [95:0] rkey();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        int         n;
        int         got[$];
        int         exp2[6];
        logic [95:0] k3[6];
        logic [95:0] k6;
        model_clear();
        exp2 = '{0, 8, 1, 9, 2, 10};

        // single request and its response
        do_reset(); db_ready = 1;
        r0_key = 96'hC0A80164_C0A80162_30390000; r0_flag = 4'b0011; r0_valid = 1;
        tick(); tick();
        chk("t1_db_valid", db_valid, 1'b1);
        chk("t1_db_key", db_key, 96'hC0A80164_C0A80162_30390000);
        chk("t1_db_flag", db_flag, 4'b0011);
        tick(); tick();
        db_resp_valid = 1; db_resp_flag = 4'b1001;
        tick();
        chk("t1_r0_resp_valid", r0_resp_valid, 1'b1);
        chk("t1_r0_resp_flag", r0_resp_flag, 4'b1001);
        chk("t1_r1_resp_valid", r1_resp_valid, 1'b0);

        // round robin with simultaneous pushes
        do_reset(); db_ready = 1;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                r0_key = rkey(); r0_flag = 4'(i);     r0_valid = 1;
                r1_key = rkey(); r1_flag = 4'(8 + i); r1_valid = 1;
            end
            tick();
            if (db_valid) got.push_back(int'(db_flag));
        end
        chk("t2_issue_count", got.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < got.size()) chk("t2_issue_order", got[i], exp2[i]);
        for (int i = 0; i < 6; i++) begin
            db_resp_valid = 1; db_resp_flag = 4'($urandom);
            tick();
            chk("t2_route_r0", r0_resp_valid, (i % 2) == 0);
            chk("t2_route_r1", r1_resp_valid, (i % 2) == 1);
        end

        // backpressure, queue overflow and drain
        do_reset(); db_ready = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                k3[i] = rkey(); r0_key = k3[i]; r0_flag = 4'(i); r0_valid = 1;
            end
            tick();
            if (i >= 1) chk("t3_hold_key", db_key, k3[0]);
        end
        chk("t3_drop_cnt0", drop_cnt0, 8'd1);
        db_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t3_drain_flag", db_flag, 4'(i));
            chk("t3_drain_key", db_key, k3[i]);
        end

        // outstanding limit
        do_reset(); db_ready = 1; n = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 6) begin
                r0_key = rkey(); r0_flag = 4'($urandom); r0_valid = 1;
                r1_key = rkey(); r1_flag = 4'($urandom); r1_valid = 1;
            end
            tick();
            if (db_valid) n++;
        end
        chk("t4_issued_at_limit", n, 8);
        db_resp_valid = 1; db_resp_flag = 4'($urandom);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (db_valid) n++;
        end
        chk("t4_issued_after_resp", n, 1);

        // orphan response
        do_reset();
        db_resp_valid = 1; db_resp_flag = 4'hA;
        tick();
        chk("t5_r0_resp", r0_resp_valid, 1'b0);
        chk("t5_r1_resp", r1_resp_valid, 1'b0);
        chk("t5_err", err_orphan, 1'b1);
        repeat (3) tick();
        chk("t5_err_sticky", err_orphan, 1'b1);

        // asynchronous reset mid-burst
        do_reset(); db_ready = 1;
        for (int i = 0; i < 4; i++) begin
            r0_key = rkey(); r0_flag = 4'($urandom); r0_valid = 1;
            tick();
        end
        chk("t6_pre_valid", db_valid, 1'b1);
        r0_valid = 1;
        eth_rst = 1;
        model_clear();
        #1;
        chk("t6_rst_db_valid", db_valid, 1'b0);
        chk("t6_rst_db_key", db_key, 96'h0);
        chk("t6_rst_db_flag", db_flag, 4'h0);
        chk("t6_rst_resp", {r0_resp_valid, r1_resp_valid, r0_resp_flag, r1_resp_flag}, 10'h0);
        chk("t6_rst_cnt", {drop_cnt0, drop_cnt1, err_orphan}, 17'h0);
        tick(); tick();
        eth_rst = 0;
        db_resp_valid = 1; db_resp_flag = 4'h6;
        tick();
        chk("t6_stale_err", err_orphan, 1'b1);
        chk("t6_stale_no_resp", r0_resp_valid | r1_resp_valid, 1'b0);
        k6 = rkey(); r1_key = k6; r1_flag = 4'b0101; r1_valid = 1;
        tick(); tick();
        chk("t6_r1_valid", db_valid, 1'b1);
        chk("t6_r1_key", db_key, k6);
        chk("t6_r1_flag", db_flag, 4'b0101);

        // drop counter saturation
        do_reset(); db_ready = 0;
        for (int i = 0; i < 265; i++) begin
            r0_key = rkey(); r0_flag = 4'($urandom); r0_valid = 1;
            tick();
        end
        chk("t7_drop_sat", drop_cnt0, 8'd255);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r0_key = rkey(); r0_flag = 4'($urandom); r0_valid = ($urandom % 3) == 0;
            r1_key = rkey(); r1_flag = 4'($urandom); r1_valid = ($urandom % 3) == 0;
            db_ready = ($urandom % 4) != 0;
            if (m_outs.size() > 0 && ($urandom % 3) == 0) begin
                db_resp_valid = 1; db_resp_flag = 4'($urandom);
            end
            tick();
        end
        db_ready = 1;
        for (int i = 0; i < 30; i++) begin
            if (m_outs.size() > 0) begin
                db_resp_valid = 1; db_resp_flag = 4'($urandom);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
